// File: rtl/crc_fifo_seq.sv
// crc_fifo_seq: SpaceWire Tx packet sequencer between the synchronous FIFO
// and the pipelined CRC-32 engine.
// - Forwards FIFO data bytes downstream and feeds each one to the CRC engine.
// - On the EOP entry it waits for the CRC pipeline to drain, appends the
//   four CRC bytes (MSB first), then sends the EOP marker (9'h100).
// Optional feature: define PKT_CNT_EN to add the o_pkt_cnt output, a
// wrapping count of accepted EOP markers.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for the FIFO to hold an entry
// S_INIT   | one-cycle crc_init pulse for the new packet
// S_READ   | popping entries, forwarding data bytes to tx and CRC
// S_DRAIN  | EOP seen; waiting CRC_LAT cycles for crc_out to settle
// S_APPEND | sending the four latched CRC bytes, MSB first
// S_TERM   | sending the EOP marker and waiting for its acceptance
module crc_fifo_seq #(
  parameter int CRC_LAT = 2,
  parameter int DW      = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_fifo_empty,
  input  logic [DW:0]   i_fifo_dout,
  output logic          o_fifo_rd,
  output logic          o_crc_init,
  output logic          o_crc_en,
  output logic [DW-1:0] o_crc_din,
  input  logic [31:0]   i_crc_out,
  output logic [DW:0]   o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
`ifdef PKT_CNT_EN
  output logic [15:0]   o_pkt_cnt,
`endif
  output logic          o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_READ,
    S_DRAIN,
    S_APPEND,
    S_TERM
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rd_q;
  logic [3:0]  r_drain_cnt;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_crc;
  logic [DW:0] r_tx_data;
  logic        r_tx_valid;
  logic        r_crc_en;
  logic [DW-1:0] r_crc_din;

  logic        w_slot_free;
  logic        w_accept;
  logic        w_rd;
  logic        w_crc_init;
  logic        w_data_beat;
  logic        w_eop_beat;
  logic        w_load_crc;
  logic        w_load_term;
  logic [DW:0] w_crc_sym;

  // The output slot can take a new symbol when empty or being drained now.
  assign w_slot_free = !r_tx_valid || i_tx_ready;
  assign w_accept    = r_tx_valid && i_tx_ready;

  // Next-state and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_crc_init  = 1'b0;
    w_data_beat = 1'b0;
    w_eop_beat  = 1'b0;
    w_load_crc  = 1'b0;
    w_load_term = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_fifo_empty) w_state_nxt = S_INIT;
      end
      S_INIT: begin
        w_crc_init  = 1'b1;
        w_state_nxt = S_READ;
      end
      S_READ: begin
        // One read in flight at most; the slot must be free so the byte
        // returned next cycle always has somewhere to go.
        w_rd = !i_fifo_empty && w_slot_free && !r_rd_q;
        if (r_rd_q) begin
          if (i_fifo_dout[DW]) begin
            w_eop_beat  = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            w_data_beat = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == 4'd0) w_state_nxt = S_APPEND;
      end
      S_APPEND: begin
        if (w_slot_free) begin
          w_load_crc = 1'b1;
          if (r_byte_idx == 2'd3) w_state_nxt = S_TERM;
        end
      end
      S_TERM: begin
        // Slot holding the marker means it was loaded; leave once accepted.
        if (r_tx_valid && r_tx_data[DW]) begin
          if (i_tx_ready) w_state_nxt = S_IDLE;
        end else if (w_slot_free) begin
          w_load_term = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select the CRC byte to append, MSB first.
  always_comb begin
    w_crc_sym = '0;
    case (r_byte_idx)
      2'd0: w_crc_sym = {1'b0, r_crc[31:24]};
      2'd1: w_crc_sym = {1'b0, r_crc[23:16]};
      2'd2: w_crc_sym = {1'b0, r_crc[15:8]};
      2'd3: w_crc_sym = {1'b0, r_crc[7:0]};
      default: w_crc_sym = '0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Delayed read strobe marks the cycle fifo_dout is valid.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rd_q <= 1'b0;
    else         r_rd_q <= w_rd;
  end

  // Drain timer and CRC capture once the pipeline has settled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_drain_cnt <= 4'd0;
      r_crc       <= 32'd0;
    end else if (w_eop_beat) begin
      r_drain_cnt <= 4'(CRC_LAT);
    end else if (r_state == S_DRAIN) begin
      if (r_drain_cnt == 4'd0) r_crc <= i_crc_out;
      else                     r_drain_cnt <= r_drain_cnt - 4'd1;
    end
  end

  // CRC byte index advances whenever a CRC byte enters the slot.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)         r_byte_idx <= 2'd0;
    else if (w_eop_beat) r_byte_idx <= 2'd0;
    else if (w_load_crc) r_byte_idx <= r_byte_idx + 2'd1;
  end

  // Output slot: load a new symbol or clear on acceptance; otherwise hold.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else if (w_data_beat) begin
      r_tx_data  <= {1'b0, i_fifo_dout[DW-1:0]};
      r_tx_valid <= 1'b1;
    end else if (w_load_crc) begin
      r_tx_data  <= w_crc_sym;
      r_tx_valid <= 1'b1;
    end else if (w_load_term) begin
      r_tx_data  <= {1'b1, {DW{1'b0}}};
      r_tx_valid <= 1'b1;
    end else if (w_accept) begin
      r_tx_valid <= 1'b0;
    end
  end

  // CRC feed, aligned with the forwarded byte; din holds when idle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_crc_en  <= 1'b0;
      r_crc_din <= '0;
    end else begin
      r_crc_en <= w_data_beat;
      if (w_data_beat) r_crc_din <= i_fifo_dout[DW-1:0];
    end
  end

`ifdef PKT_CNT_EN
  logic [15:0] r_pkt_cnt;

  // Count accepted EOP markers, wrapping naturally at 16 bits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                         r_pkt_cnt <= 16'd0;
    else if (w_accept && r_tx_data[DW])  r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end

  assign o_pkt_cnt = r_pkt_cnt;
`endif

  assign o_fifo_rd  = w_rd;
  assign o_crc_init = w_crc_init;
  assign o_crc_en   = r_crc_en;
  assign o_crc_din  = r_crc_din;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_crc_fifo_seq.sv
// Testbench for crc_fifo_seq: FIFO model, behavioural CRC-32 engine with
// CRC_LAT latency, random tx_ready back-pressure, and an expected symbol
// stream built from packet contents (bytes, CRC-32 MSB first, EOP marker).
module tb_crc_fifo_seq;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fifo_empty;
  logic [8:0]  fifo_dout;
  logic        fifo_rd;
  logic        crc_init;
  logic        crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc_out;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
`ifdef PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  crc_fifo_seq #(.CRC_LAT(LAT), .DW(8)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_fifo_empty(fifo_empty),
    .i_fifo_dout(fifo_dout),
    .o_fifo_rd(fifo_rd),
    .o_crc_init(crc_init),
    .o_crc_en(crc_en),
    .o_crc_din(crc_din),
    .i_crc_out(crc_out),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
`ifdef PKT_CNT_EN
    .o_pkt_cnt(pkt_cnt),
`endif
    .o_busy(busy)
  );

  // Reference CRC-32 (reflected, poly EDB88320) one byte step.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // FIFO model
  logic [8:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit rd_pending = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    #1;
    if (rd_pending) begin
      fifo_dout = fmem[rd_ptr & 255];
      rd_ptr++;
    end
  end

  // Back-pressure: 0 always ready, 1 random, 2 held low
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 3) != 0);
      default: tx_ready = 1'b0;
    endcase
  end

  // CRC engine model: crc_out reflects a byte LAT cycles after its crc_en
  logic [31:0] eng_state;
  logic [31:0] eng_pipe [LAT];
  bit          s_init, s_en;
  logic [7:0]  s_din;
  always @(posedge clk) begin
    #1;
    if (s_init)    eng_state = 32'hFFFFFFFF;
    else if (s_en) eng_state = crc_byte(eng_state, s_din);
    for (int i = LAT - 1; i > 0; i--) eng_pipe[i] = eng_pipe[i-1];
    eng_pipe[0] = ~eng_state;
    crc_out = eng_pipe[LAT-1];
  end

  // Monitor, sampled on the falling edge
  logic [8:0] tx_log [$];
  int n_init = 0, n_en = 0, n_rd_empty = 0, n_unstable = 0;
  bit prev_stall = 0;
  logic [8:0] prev_data = '0;
  always @(negedge clk) begin
    rd_pending = fifo_rd;
    s_init = crc_init;
    s_en   = crc_en;
    s_din  = crc_din;
    if (!reset) begin
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (crc_init) n_init++;
      if (crc_en) n_en++;
      if (fifo_rd && fifo_empty) n_rd_empty++;
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) n_unstable++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 0;
    end
  end

  // Packet staging and expected stream
  logic [7:0] pkt [$];
  logic [8:0] exp_q [$];

  task automatic load_packet();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pkt[i]) begin
      c = crc_byte(c, pkt[i]);
      exp_q.push_back({1'b0, pkt[i]});
    end
    c = ~c;
    exp_q.push_back({1'b0, c[31:24]});
    exp_q.push_back({1'b0, c[23:16]});
    exp_q.push_back({1'b0, c[15:8]});
    exp_q.push_back({1'b0, c[7:0]});
    exp_q.push_back(9'h100);
    @(posedge clk); #1;
    foreach (pkt[i]) begin
      fmem[wr_ptr & 255] = {1'b0, pkt[i]};
      wr_ptr++;
    end
    fmem[wr_ptr & 255] = 9'h100;
    wr_ptr++;
  endtask

  task automatic rand_packet(input int max_len);
    int len;
    len = $urandom_range(0, max_len);
    pkt.delete();
    repeat (len) pkt.push_back(8'($urandom));
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tx_log.size() >= exp_q.size() && !busy && fifo_empty) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({fifo_rd, crc_init, crc_en, busy, tx_valid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got rd/init/en/busy/valid=%b, required 00000",
               {fifo_rd, crc_init, crc_en, busy, tx_valid});
    end
    tests_run++;
    if ({tx_data, crc_din} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got tx_data=%h crc_din=%h, required 0", tx_data, crc_din);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || fifo_rd !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_empty: got busy=%b fifo_rd=%b, required 0 0", busy, fifo_rd);
    end
  endtask

  task automatic test_known_vector();
    bit ok;
    int i0, e0;
    logic [8:0] got;
    logic [8:0] crc_exp [4];
    crc_exp = '{9'h0CB, 9'h0F4, 9'h039, 9'h026};
    tx_log.delete(); exp_q.delete();
    i0 = n_init; e0 = n_en;
    pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    ready_mode = 0;
    load_packet();
    wait_done(ok);
    tests_run++;
    if (!ok || tx_log.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL known_len: got %0d symbols, required %0d", tx_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL known_sym[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      got = (9 + i < tx_log.size()) ? tx_log[9+i] : 9'h1FF;
      tests_run++;
      if (got !== crc_exp[i]) begin
        tests_failed++;
        $display("FAIL known_crc[%0d]: got %h, required %h", i, got, crc_exp[i]);
      end
    end
    tests_run++;
    if (n_init - i0 != 1 || n_en - e0 != 9) begin
      tests_failed++;
      $display("FAIL known_pulses: got init=%0d en=%0d, required init=1 en=9", n_init - i0, n_en - e0);
    end
  endtask

  task automatic test_empty_packet();
    bit ok;
    int i0, e0;
    logic [8:0] got;
    tx_log.delete(); exp_q.delete();
    i0 = n_init; e0 = n_en;
    pkt.delete();
    ready_mode = 1;
    load_packet();
    wait_done(ok);
    tests_run++;
    if (!ok || tx_log.size() != 5) begin
      tests_failed++;
      $display("FAIL empty_len: got %0d symbols, required 5", tx_log.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL empty_sym[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
    tests_run++;
    if (n_init - i0 != 1 || n_en - e0 != 0) begin
      tests_failed++;
      $display("FAIL empty_pulses: got init=%0d en=%0d, required init=1 en=0", n_init - i0, n_en - e0);
    end
  endtask

  task automatic test_stall();
    bit ok, seen;
    int u0;
    logic [8:0] held, got;
    tx_log.delete(); exp_q.delete();
    u0 = n_unstable;
    pkt = '{8'hA5, 8'h3C, 8'h7E};
    ready_mode = 0;
    load_packet();
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    ready_mode = 2;
    @(negedge clk);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (tx_valid && !tx_ready) seen = 1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL stall_start: got no stalled symbol, required one within 20 cycles");
    end
    held = tx_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== held || fifo_rd !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%h rd=%b, required 1 %h 0",
                 c, tx_valid, tx_data, fifo_rd, held);
      end
    end
    ready_mode = 1;
    wait_done(ok);
    tests_run++;
    if (!ok || tx_log.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL stall_len: got %0d symbols, required %0d", tx_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL stall_sym[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
    tests_run++;
    if (n_unstable != u0) begin
      tests_failed++;
      $display("FAIL stall_stable: got %0d unstable cycles, required 0", n_unstable - u0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int i0;
    logic [8:0] got;
`ifdef PKT_CNT_EN
    logic [15:0] p0;
    p0 = pkt_cnt;
`endif
    tx_log.delete(); exp_q.delete();
    i0 = n_init;
    ready_mode = 1;
    rand_packet(6);
    pkt.push_back(8'h5A);
    load_packet();
    rand_packet(6);
    load_packet();
    wait_done(ok);
    tests_run++;
    if (!ok || tx_log.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_len: got %0d symbols, required %0d", tx_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL b2b_sym[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
    tests_run++;
    if (n_init - i0 != 2) begin
      tests_failed++;
      $display("FAIL b2b_init: got %0d crc_init pulses, required 2", n_init - i0);
    end
`ifdef PKT_CNT_EN
    tests_run++;
    if (pkt_cnt !== 16'(p0 + 16'd2)) begin
      tests_failed++;
      $display("FAIL b2b_pkt_cnt: got %h, required %h", pkt_cnt, 16'(p0 + 16'd2));
    end
`endif
  endtask

  task automatic test_random();
    bit ok;
    logic [8:0] got;
    tx_log.delete(); exp_q.delete();
    ready_mode = 1;
    for (int p = 0; p < 8; p++) begin
      rand_packet(12);
      load_packet();
    end
    wait_done(ok);
    tests_run++;
    if (!ok || tx_log.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_len: got %0d symbols, required %0d", tx_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rand_sym[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
    tests_run++;
    if (n_rd_empty != 0 || n_unstable != 0) begin
      tests_failed++;
      $display("FAIL rand_protocol: got rd_while_empty=%0d unstable=%0d, required 0 0",
               n_rd_empty, n_unstable);
    end
  endtask

  task automatic test_reset_mid_append();
    bit ok, hit;
    int n;
    logic [8:0] got;
    tx_log.delete(); exp_q.delete();
    ready_mode = 0;
    pkt.delete();
    repeat (4) pkt.push_back(8'($urandom));
    n = pkt.size();
    load_packet();
    hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      if (tx_log.size() >= n + 1) hit = 1;
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL rst_reach_append: got %0d symbols, required %0d", tx_log.size(), n + 1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({fifo_rd, crc_init, crc_en, busy, tx_valid, tx_data, crc_din} !== 22'd0) begin
      tests_failed++;
      $display("FAIL rst_outputs: got rd=%b init=%b en=%b busy=%b valid=%b data=%h din=%h, required all 0",
               fifo_rd, crc_init, crc_en, busy, tx_valid, tx_data, crc_din);
    end
    for (int i = 0; i < n + 1; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rst_prefix[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tx_log.delete(); exp_q.delete();
    ready_mode = 1;
    rand_packet(8);
    load_packet();
    wait_done(ok);
    tests_run++;
    if (!ok || tx_log.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rst_next_len: got %0d symbols, required %0d", tx_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rst_next_sym[%0d]: got %h, required %h", i, got, exp_q[i]);
      end
    end
  endtask

`ifdef PKT_CNT_EN
  task automatic test_pkt_wrap();
    bit ok;
    tx_log.delete(); exp_q.delete();
    @(negedge clk);
    force dut.r_pkt_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_pkt_cnt;
    ready_mode = 1;
    pkt = '{8'h11, 8'h22};
    load_packet();
    wait_done(ok);
    tests_run++;
    if (!ok || pkt_cnt !== 16'h0000) begin
      tests_failed++;
      $display("FAIL pkt_wrap: got pkt_cnt=%h done=%b, required 0000 1", pkt_cnt, ok);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    tx_ready = 1'b1;
    fifo_dout = '0;
    eng_state = 32'hFFFFFFFF;
    for (int i = 0; i < LAT; i++) eng_pipe[i] = '0;
    crc_out = '0;
    test_reset();
    test_known_vector();
    test_empty_packet();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_append();
`ifdef PKT_CNT_EN
    test_pkt_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
